// File: rtl/lcd_ctrl_pkg.sv
// Shared types and LCD command constants for the 2x16 character LCD refresh controller.
package lcd_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_PWR,
      ST_INIT,
      ST_ADDR,
      ST_FETCH,
      ST_WRITE
   } state_t;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_STROBE,
      PH_HOLD
   } phase_t;

   localparam logic [7:0] CMD_FUNC  = 8'h38;
   localparam logic [7:0] CMD_DISP  = 8'h0C;
   localparam logic [7:0] CMD_ENTRY = 8'h06;
   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_LINE1 = 8'h80;
   localparam logic [7:0] CMD_LINE2 = 8'hC0;

   localparam int INIT_LEN = 4;

   // Init command ROM, entry 0 is issued first.
   localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {CMD_CLEAR, CMD_ENTRY, CMD_DISP, CMD_FUNC};

   localparam logic [4:0] LAST_L1   = 5'd15;
   localparam logic [4:0] FIRST_L2  = 5'd16;
   localparam logic [4:0] LAST_CELL = 5'd31;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_write_timer.sv
// One LCD bus write: setup cycle, enable strobe, then post-write wait.
// Out of reset the counter runs the power-up wait, so the same down-counter
// covers every delay in the controller.
module lcd_write_timer
   import lcd_ctrl_pkg::*;
#(
   parameter int unsigned PWR_WAIT = 20,
   parameter int unsigned E_CYCLES = 12,
   parameter int unsigned CMD_WAIT = 2000,
   parameter int unsigned CLR_WAIT = 80000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rs,
   input  logic [7:0] data,
   input  logic       long_wait,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic [7:0] lcd_data,
   output logic       done
);

   localparam int unsigned MAX_CNT = max_u(max_u(PWR_WAIT, CLR_WAIT), max_u(CMD_WAIT, E_CYCLES));
   localparam int CNT_W = $clog2(MAX_CNT + 1);

   phase_t           phase;
   phase_t           phase_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             long_q;
   logic             long_nxt;
   logic             rs_nxt;
   logic [7:0]       data_nxt;
   logic             cnt_last;

   assign cnt_last = (cnt == CNT_W'(1));
   assign done     = (phase == PH_HOLD) && cnt_last;
   assign lcd_e    = (phase == PH_STROBE);

   // Phase sequencing; a start in the last wait cycle chains straight into the next setup.
   always_comb begin
      phase_nxt = phase;
      cnt_nxt   = cnt;
      long_nxt  = long_q;
      rs_nxt    = lcd_rs;
      data_nxt  = lcd_data;
      case (phase)
         PH_IDLE: begin
         end
         PH_SETUP: begin
            phase_nxt = PH_STROBE;
            cnt_nxt   = CNT_W'(E_CYCLES);
         end
         PH_STROBE: begin
            if (cnt_last) begin
               phase_nxt = PH_HOLD;
               cnt_nxt   = long_q ? CNT_W'(CLR_WAIT) : CNT_W'(CMD_WAIT);
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         PH_HOLD: begin
            if (cnt_last) begin
               phase_nxt = PH_IDLE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: phase_nxt = PH_IDLE;
      endcase
      if (start && ((phase == PH_IDLE) || done)) begin
         phase_nxt = PH_SETUP;
         rs_nxt    = rs;
         data_nxt  = data;
         long_nxt  = long_wait;
      end
   end

   // Bus and counter registers; reset parks the timer in the power-up wait.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase    <= PH_HOLD;
         cnt      <= CNT_W'(PWR_WAIT);
         long_q   <= 1'b0;
         lcd_rs   <= 1'b0;
         lcd_data <= 8'h00;
      end else begin
         phase    <= phase_nxt;
         cnt      <= cnt_nxt;
         long_q   <= long_nxt;
         lcd_rs   <= rs_nxt;
         lcd_data <= data_nxt;
      end
   end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// HD44780 2x16 refresh controller: power-up wait, init commands, then endless
// refresh of 32 cells fetched from a registered character source.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_PWR   | power-up wait running in the write timer
// ST_INIT  | init command init_step in flight (0x38, 0x0C, 0x06, 0x01)
// ST_ADDR  | line address command (0x80 / 0xC0) in flight
// ST_FETCH | two-cycle wait for char_data to follow char_index
// ST_WRITE | character write for char_index in flight
module lcd_refresh_ctrl
   import lcd_ctrl_pkg::*;
#(
   parameter int unsigned PWR_WAIT = 20,
   parameter int unsigned E_CYCLES = 12,
   parameter int unsigned CMD_WAIT = 2000,
   parameter int unsigned CLR_WAIT = 80000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] char_data,
   output logic [4:0] char_index,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data,
   output logic       init_done,
   output logic       frame_done
);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] init_step;
   logic [1:0] step_nxt;
   logic       fetch_ph;
   logic       fetch_nxt;
   logic [4:0] index_nxt;
   logic       init_done_nxt;
   logic       frame_done_nxt;

   logic       wr_start;
   logic       wr_rs;
   logic [7:0] wr_data;
   logic       wr_long;
   logic       wr_done;

   assign lcd_rw = 1'b0;

   lcd_write_timer #(
      .PWR_WAIT (PWR_WAIT),
      .E_CYCLES (E_CYCLES),
      .CMD_WAIT (CMD_WAIT),
      .CLR_WAIT (CLR_WAIT)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .start     (wr_start),
      .rs        (wr_rs),
      .data      (wr_data),
      .long_wait (wr_long),
      .lcd_e     (lcd_e),
      .lcd_rs    (lcd_rs),
      .lcd_data  (lcd_data),
      .done      (wr_done)
   );

   // Next state and write requests; commands are launched in the last wait
   // cycle of the previous write so writes run back to back.
   always_comb begin
      state_nxt      = state;
      step_nxt       = init_step;
      fetch_nxt      = fetch_ph;
      index_nxt      = char_index;
      init_done_nxt  = init_done;
      frame_done_nxt = 1'b0;
      wr_start       = 1'b0;
      wr_rs          = 1'b0;
      wr_data        = 8'h00;
      wr_long        = 1'b0;
      case (state)
         ST_PWR: begin
            if (wr_done) begin
               step_nxt  = 2'd0;
               wr_start  = 1'b1;
               wr_data   = INIT_ROM[0];
               state_nxt = ST_INIT;
            end
         end
         ST_INIT: begin
            if (wr_done) begin
               if (init_step == 2'(INIT_LEN - 1)) begin
                  init_done_nxt = 1'b1;
                  index_nxt     = 5'd0;
                  wr_start      = 1'b1;
                  wr_data       = CMD_LINE1;
                  state_nxt     = ST_ADDR;
               end else begin
                  step_nxt = init_step + 2'd1;
                  wr_start = 1'b1;
                  wr_data  = INIT_ROM[step_nxt];
                  wr_long  = (INIT_ROM[step_nxt] == CMD_CLEAR);
               end
            end
         end
         ST_ADDR: begin
            if (wr_done) begin
               fetch_nxt = 1'b0;
               state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            // Source output lags char_index by one register; take it on the second edge.
            if (!fetch_ph) begin
               fetch_nxt = 1'b1;
            end else begin
               wr_start  = 1'b1;
               wr_rs     = 1'b1;
               wr_data   = char_data;
               state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (wr_done) begin
               if (char_index == LAST_L1) begin
                  index_nxt = FIRST_L2;
                  wr_start  = 1'b1;
                  wr_data   = CMD_LINE2;
                  state_nxt = ST_ADDR;
               end else if (char_index == LAST_CELL) begin
                  index_nxt      = 5'd0;
                  frame_done_nxt = 1'b1;
                  wr_start       = 1'b1;
                  wr_data        = CMD_LINE1;
                  state_nxt      = ST_ADDR;
               end else begin
                  index_nxt = char_index + 5'd1;
                  fetch_nxt = 1'b0;
                  state_nxt = ST_FETCH;
               end
            end
         end
         default: state_nxt = ST_PWR;
      endcase
   end

   // State, index and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_PWR;
         init_step  <= 2'd0;
         fetch_ph   <= 1'b0;
         char_index <= 5'd0;
         init_done  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         init_step  <= step_nxt;
         fetch_ph   <= fetch_nxt;
         char_index <= index_nxt;
         init_done  <= init_done_nxt;
         frame_done <= frame_done_nxt;
      end
   end

endmodule
